// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Clocked ALU with internal {N,Z,V,R,C} flag register, an
//                iterative shift-add unsigned multiplier with a HI register,
//                valid/ready handshakes on input and output, and a single
//                registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    // Step counter must reach WIDTH, which marks the completion cycle.
    localparam int            CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] STEPS = CW'(WIDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    // Flag bit positions inside {N,Z,V,R,C}
    localparam int FC = 0;
    localparam int FR = 1;
    localparam int FV = 2;
    localparam int FZ = 3;
    localparam int FN = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ASR  = 4'hA;
    localparam logic [3:0] OP_RCL  = 4'hB;
    localparam logic [3:0] OP_RCR  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_MFHI = 4'hE;
    localparam logic [3:0] OP_CMP  = 4'hF;

    // Architectural and multiplier state
    logic [0:0]         state_q,     state_d;
    logic [CW-1:0]      cnt_q,       cnt_d;
    logic [2*WIDTH-1:0] mcand_q,     mcand_d;
    logic [WIDTH-1:0]   mplier_q,    mplier_d;
    logic [2*WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0]   hi_q,        hi_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic [4:0]         flags_q,     flags_d;
    logic               out_valid_q, out_valid_d;

    // Handshake and sequencing qualifiers
    logic w_accept;
    logic w_single;
    logic w_mul_start;
    logic w_mul_done;

    assign in_ready    = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (op == OP_MUL);
    assign w_single    = w_accept && (op != OP_MUL);
    assign w_mul_done  = (state_q == ST_MUL) && (cnt_q == STEPS);

    // Shared adder for ADD/ADC/SUB/SBC/CMP
    logic               w_cin;
    logic [WIDTH-1:0]   w_bop;
    logic [WIDTH:0]     w_sum;
    logic               w_ovf;

    // Operand-B inversion and carry-in selection for the shared adder
    always_comb begin
        w_bop = b;
        w_cin = 1'b0;
        case (op)
            OP_ADC:         w_cin = flags_q[FC];
            OP_SUB, OP_CMP: begin w_bop = ~b; w_cin = 1'b1;         end
            OP_SBC:         begin w_bop = ~b; w_cin = flags_q[FC];  end
            default:        w_cin = 1'b0;
        endcase
        w_sum = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
        w_ovf = (a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    end

    // Result and flag update for every single-cycle opcode
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_zn_src;
    logic [4:0]       w_f;

    always_comb begin
        w_y = '0;
        w_f = flags_q;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                w_y     = w_sum[WIDTH-1:0];
                w_f[FC] = w_sum[WIDTH];
                w_f[FV] = w_ovf;
            end
            OP_CMP: begin
                w_y     = a;
                w_f[FC] = w_sum[WIDTH];
                w_f[FV] = w_ovf;
            end
            OP_AND:  w_y = a & b;
            OP_OR:   w_y = a | b;
            OP_XOR:  w_y = a ^ b;
            OP_NOT:  w_y = ~a;
            OP_SHL:  begin w_y = {a[WIDTH-2:0], 1'b0};        w_f[FR] = a[WIDTH-1]; end
            OP_SHR:  begin w_y = {1'b0, a[WIDTH-1:1]};        w_f[FR] = a[0];       end
            OP_ASR:  begin w_y = {a[WIDTH-1], a[WIDTH-1:1]};  w_f[FR] = a[0];       end
            OP_RCL:  begin w_y = {a[WIDTH-2:0], flags_q[FR]}; w_f[FR] = a[WIDTH-1]; end
            OP_RCR:  begin w_y = {flags_q[FR], a[WIDTH-1:1]}; w_f[FR] = a[0];       end
            OP_MFHI: w_y = hi_q;
            default: w_y = '0;
        endcase
        // CMP reports Z/N of the difference while Y carries A through
        w_zn_src = (op == OP_CMP) ? w_sum[WIDTH-1:0] : w_y;
        w_f[FZ]  = (w_zn_src == '0);
        w_f[FN]  = w_zn_src[WIDTH-1];
    end

    // Flags written when the multiply completes
    logic [4:0] w_mf;

    always_comb begin
        w_mf     = flags_q;
        w_mf[FC] = (acc_q[2*WIDTH-1:WIDTH] != '0);
        w_mf[FV] = 1'b0;
        w_mf[FZ] = (acc_q == '0);
        w_mf[FN] = acc_q[WIDTH-1];
    end

    // Next-state logic: control FSM, multiplier steps and output register
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q && !out_ready;

        if (w_single) begin
            result_d    = w_y;
            flags_d     = w_f;
            out_valid_d = 1'b1;
        end

        if (w_mul_start) begin
            state_d  = ST_MUL;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end

        if (state_q == ST_MUL) begin
            if (w_mul_done) begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                result_d    = acc_q[WIDTH-1:0];
                hi_d        = acc_q[2*WIDTH-1:WIDTH];
                flags_d     = w_mf;
                out_valid_d = 1'b1;
            end else begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            hi_q        <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
`default_nettype wire
